// File: rtl/isp_frame_control.sv
// isp_frame_control: frame sequencer for the WB/CC pipeline. Counts input pixels, delays
// data_valid by PIPE_LAT and issues linear frame-buffer writes. `define ISP_CTRL_PINGPONG_EN for A/B buffering.
module isp_frame_control #(
  parameter int ADDR_W        = 32,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int BYTES_PER_PIX = 4,
  parameter int PIPE_LAT      = 3,
  parameter int NUM_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  new_frame,
  input  logic                  data_valid,
  input  logic [NUM_STAGES-1:0] cfg_stage_en,
  input  logic [ADDR_W-1:0]     frame_buffer_base_adr,
`ifdef ISP_CTRL_PINGPONG_EN
  input  logic [ADDR_W-1:0]     frame_buffer_base_adr_b,
  output logic                  buf_sel,
`endif
  output logic                  write_enable,
  output logic [ADDR_W-1:0]     write_address,
  output logic [NUM_STAGES-1:0] stage_enable,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);
  localparam int TOTAL = FRAME_W * FRAME_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADR_INC  = ADDR_W'(BYTES_PER_PIX);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                state;
  logic [CNT_W-1:0]      in_cnt;
  logic [ADDR_W-1:0]     next_adr, base_sel, adr_cur;
  logic [PIPE_LAT:1]     vld_pipe;
  logic [PIPE_LAT-1:0]   vld_tap;
  logic                  accept, last_pix, promote, drain_end;

`ifdef ISP_CTRL_PINGPONG_EN
  assign base_sel = buf_sel ? frame_buffer_base_adr_b : frame_buffer_base_adr;
`else
  assign base_sel = frame_buffer_base_adr;
`endif

  // new_frame always (re)starts a frame; a coincident data_valid is pixel 0
  assign accept   = data_valid && (new_frame || state == ACTIVE);
  assign last_pix = accept && (new_frame ? (TOTAL == 1) : (in_cnt == LAST_PIX));

  if (PIPE_LAT > 1) begin : g_tap
    assign vld_tap = {vld_pipe[PIPE_LAT-1:1], accept};
  end else begin : g_tap1
    assign vld_tap = accept;
  end

  assign write_enable = vld_pipe[PIPE_LAT];
  // the entry about to become a write; entries in flight are dropped on a restart
  assign promote   = vld_tap[PIPE_LAT-1] && !(new_frame && PIPE_LAT > 1);
  assign adr_cur   = new_frame ? base_sel : next_adr;
  assign drain_end = (state == DRAIN) && !new_frame && vld_pipe[PIPE_LAT] && !(|vld_tap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      in_cnt        <= '0;
      vld_pipe      <= '0;
      next_adr      <= '0;
      write_address <= '0;
      stage_enable  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
`ifdef ISP_CTRL_PINGPONG_EN
      buf_sel       <= 1'b0;
`endif
    end else begin
      frame_done <= drain_end;
      vld_pipe   <= new_frame ? PIPE_LAT'(accept) : vld_tap;
      if (promote) begin
        write_address <= adr_cur;
        next_adr      <= adr_cur + ADR_INC;
      end else if (new_frame) begin
        next_adr <= base_sel;
      end
      if ((new_frame && state != IDLE) || (data_valid && state == DRAIN))
        overrun <= 1'b1;
      if (new_frame) begin
        state        <= last_pix ? DRAIN : ACTIVE;
        in_cnt       <= CNT_W'(accept);
        stage_enable <= cfg_stage_en;
        busy         <= 1'b1;
      end else begin
        case (state)
          ACTIVE: if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (last_pix) state <= DRAIN;
          end
          DRAIN: if (drain_end) begin
            state        <= IDLE;
            stage_enable <= '0;
            busy         <= 1'b0;
`ifdef ISP_CTRL_PINGPONG_EN
            buf_sel      <= ~buf_sel;
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_isp_frame_control.sv
// Scoreboard bench for isp_frame_control: the driver models frames at transaction level and
// queues expected writes / frame_done cycles; a negedge monitor pops and compares.
module tb_isp_frame_control;
  localparam int AW = 32, FW = 4, FH = 2, BPP = 4, LAT = 3, NS = 2, TOTAL = FW * FH;
`ifdef ISP_CTRL_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0, reset_n = 1'b0, new_frame = 1'b0, data_valid = 1'b0;
  logic [NS-1:0] cfg_stage_en = '0;
  logic [AW-1:0] base_a = 32'h1000, base_b = 32'h2000;
  logic          write_enable, busy, frame_done, overrun;
  logic [AW-1:0] write_address;
  logic [NS-1:0] stage_enable;
`ifdef ISP_CTRL_PINGPONG_EN
  logic          buf_sel;
`endif

  int checks = 0, failures = 0, cyc = 0;

  typedef struct packed {int c; logic [AW-1:0] adr;} wr_t;
  wr_t wq[$];
  int  dq[$];

  bit            m_busy, m_ovr, m_bsel, m_done_pend;
  int            m_cnt, m_done_cyc;
  logic [AW-1:0] m_base, last_adr;
  logic [NS-1:0] m_stage;

  isp_frame_control #(.ADDR_W(AW), .FRAME_W(FW), .FRAME_H(FH), .BYTES_PER_PIX(BPP),
                      .PIPE_LAT(LAT), .NUM_STAGES(NS)) dut (
    .clk(clk), .reset_n(reset_n), .new_frame(new_frame), .data_valid(data_valid),
    .cfg_stage_en(cfg_stage_en), .frame_buffer_base_adr(base_a),
`ifdef ISP_CTRL_PINGPONG_EN
    .frame_buffer_base_adr_b(base_b), .buf_sel(buf_sel),
`endif
    .write_enable(write_enable), .write_address(write_address), .stage_enable(stage_enable),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // monitor: every cycle the strobes must match exactly what the scoreboard holds for this cycle
  always @(negedge clk) begin
    bit exp_we, exp_fd;
    if (!reset_n) begin
      last_adr = '0;
    end else begin
      exp_we = (wq.size() > 0 && wq[0].c == cyc);
      chk("write_enable", write_enable, exp_we);
      if (exp_we) begin
        chk("write_address", write_address, wq[0].adr);
        last_adr = wq[0].adr;
        void'(wq.pop_front());
      end else begin
        chk("write_address_hold", write_address, last_adr);
      end
      exp_fd = (dq.size() > 0 && dq[0] == cyc);
      chk("frame_done", frame_done, exp_fd);
      if (exp_fd) void'(dq.pop_front());
    end
  end

  task automatic model_clear();
    wq.delete(); dq.delete();
    m_busy = 0; m_ovr = 0; m_bsel = 0; m_done_pend = 0; m_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_write_enable", write_enable, 0);
    chk("rst_write_address", write_address, 0);
    chk("rst_stage_enable", stage_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
`ifdef ISP_CTRL_PINGPONG_EN
    chk("rst_buf_sel", buf_sel, 0);
`endif
  endtask

  // asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2;
    reset_n = 1'b0; new_frame = 1'b0; data_valid = 1'b0;
    #1;
    check_reset_outputs();
    model_clear();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // one cycle of stimulus; the model describes frames, not the DUT's internal state
  task automatic step(input bit nf, input bit dv, input logic [NS-1:0] cfg);
    if (m_done_pend && cyc >= m_done_cyc) begin
      m_busy = 0; m_done_pend = 0; m_bsel = ~m_bsel;
    end
    chk("busy", busy, m_busy);
    chk("stage_enable", stage_enable, m_busy ? m_stage : '0);
    chk("overrun", overrun, m_ovr);
`ifdef ISP_CTRL_PINGPONG_EN
    chk("buf_sel", buf_sel, m_bsel);
`endif
    new_frame = nf; data_valid = dv; cfg_stage_en = cfg;
    if (nf) begin
      if (m_busy) begin
        m_ovr = 1;
        while (wq.size() > 0 && wq[$].c > cyc) void'(wq.pop_back());
        if (m_done_pend) void'(dq.pop_back());
        m_done_pend = 0;
      end
      m_busy = 1; m_cnt = 0; m_stage = cfg;
      m_base = (PP && m_bsel) ? base_b : base_a;
    end
    if (dv && m_busy) begin
      if (m_cnt < TOTAL) begin
        wq.push_back('{c: cyc + LAT, adr: m_base + AW'(m_cnt * BPP)});
        m_cnt++;
        if (m_cnt == TOTAL) begin
          m_done_pend = 1; m_done_cyc = cyc + LAT + 1;
          dq.push_back(m_done_cyc);
        end
      end else begin
        m_ovr = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, NS'($urandom));
  endtask

  task automatic frame_b2b(input int n, input logic [NS-1:0] cfg);
    step(1, 1, cfg);
    for (int i = 1; i < n; i++) step(0, 1, NS'($urandom));
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;

    // mid-frame reset
    frame_b2b(4, 2'b11);
    do_reset();

    // back-to-back frame; cfg changes mid-frame must not matter
    frame_b2b(TOTAL, 2'b11);
    idle(6);

    // valids with random 1-3 cycle gaps
    step(1, 1, 2'b01);
    for (int i = 1; i < TOTAL; i++) begin
      idle($urandom_range(3, 1));
      step(0, 1, NS'($urandom));
    end
    idle(6);

    // one pixel too many
    frame_b2b(TOTAL + 1, 2'b10);
    idle(6);

    // abort after 3 pixels, then a full frame
    frame_b2b(3, 2'b11);
    frame_b2b(TOTAL, 2'b01);
    idle(6);
    do_reset();

    // address wrap, then ping-pong alternation over following frames
    base_a = 32'hFFFF_FFF8;
    frame_b2b(TOTAL, 2'b11);
    idle(6);
    base_a = 32'h1000;
    frame_b2b(TOTAL, 2'b10);
    idle(5);
    frame_b2b(TOTAL, 2'b01);
    idle(6);

    // random traffic with occasional restarts
    for (int i = 0; i < 400; i++)
      step($urandom_range(39, 0) == 0, $urandom_range(2, 0) != 0, NS'($urandom));
    idle(12);

    chk("pending_writes", wq.size(), 0);
    chk("pending_frame_done", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
